// File: rtl/fmps_pkg.sv
// fmps_pkg: shared definitions for the FMPS receive-side link monitor.
//   - FMPS_HEADER_MAGIC    : default value of header bits [31:16]
//   - ST_*                 : status codes reported on statusCode
//   - CSR_*_BIT            : fixed CSR readback bit positions
//   - parserState_t        : per-link parser state encoding
//   - csrCcwInhibitBit()   : CSR write bit position of the CCW inhibit,
//                            which depends on the index width
package fmps_pkg;

    localparam logic [15:0] FMPS_HEADER_MAGIC = 16'hB6CF;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_BAD_MAGIC = 3'd1;
    localparam logic [2:0] ST_DUPLICATE = 3'd2;
    localparam logic [2:0] ST_TRUNCATED = 3'd3;
    localparam logic [2:0] ST_OVERLONG  = 3'd4;

    localparam int CSR_ACTIVE_BIT = 31;
    localparam int CSR_VALID_BIT  = 30;

    typedef enum logic [1:0] {
        PS_HEADER  = 2'd0,
        PS_DATA    = 2'd1,
        PS_DISCARD = 2'd2
    } parserState_t;

    // The inhibit bits sit just above three index-sized CSR fields.
    function automatic int csrCcwInhibitBit(input int indexWidth);
        return 3 * (indexWidth + 1);
    endfunction

endpackage

// File: rtl/fmps_link_parser.sv
// fmps_link_parser: one FMPS link tap. Validates the header, stores the
// payload word in a local RAM at the header's index and keeps the bitmap of
// indices received since the last clearBitmap.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clearBitmap       start of a new FA cycle (a write in this cycle still lands)
//   tValid/tLast/tData link tap (always ready)
//   rdAddrA/rdAddrB   asynchronous RAM read addresses
//   rdDataA/rdDataB   RAM words at those addresses
//   bitmap            indices received this cycle
//   errValid/errCode  combinational error report for the current beat
module fmps_link_parser
    import fmps_pkg::*;
#(
    parameter int          INDEX_WIDTH     = 5,
    parameter logic [15:0] HEADER_MAGIC    = FMPS_HEADER_MAGIC,
    parameter int          INDEX_START_BIT = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clearBitmap,
    input  logic                        tValid,
    input  logic                        tLast,
    input  logic [31:0]                 tData,
    input  logic [INDEX_WIDTH-1:0]      rdAddrA,
    input  logic [INDEX_WIDTH-1:0]      rdAddrB,
    output logic [31:0]                 rdDataA,
    output logic [31:0]                 rdDataB,
    output logic [(2**INDEX_WIDTH)-1:0] bitmap,
    output logic                        errValid,
    output logic [2:0]                  errCode
);

    localparam int DEPTH = 2**INDEX_WIDTH;

    parserState_t            state_r;
    parserState_t            stateNext_s;
    logic [INDEX_WIDTH-1:0]  index_r;
    logic [DEPTH-1:0]        bitmap_r;
    logic [DEPTH-1:0]        bitmapNext_s;
    logic [31:0]             ram_r [DEPTH];
    logic                    ramWe_s;
    logic                    magicOk_s;
    logic                    duplicate_s;
    logic                    errValid_s;
    logic [2:0]              errCode_s;

    assign magicOk_s   = (tData[31:16] == HEADER_MAGIC);
    // A bit cleared by this cycle's FAstrobe does not count as a duplicate.
    assign duplicate_s = bitmap_r[index_r] && !clearBitmap;

    // Parser state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= PS_HEADER;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Parser next-state logic.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            PS_HEADER: begin
                if (tValid && !tLast) begin
                    stateNext_s = magicOk_s ? PS_DATA : PS_DISCARD;
                end else begin
                    // Idle, or a single-beat packet: stay aligned on headers.
                    stateNext_s = PS_HEADER;
                end
            end
            PS_DATA: begin
                if (tValid) begin
                    stateNext_s = tLast ? PS_HEADER : PS_DISCARD;
                end else begin
                    stateNext_s = PS_DATA;
                end
            end
            PS_DISCARD: begin
                if (tValid && tLast) begin
                    stateNext_s = PS_HEADER;
                end else begin
                    stateNext_s = PS_DISCARD;
                end
            end
            default: stateNext_s = PS_HEADER;
        endcase
    end

    // Parser outputs: RAM write enable and error report for the current beat.
    always_comb begin
        ramWe_s    = 1'b0;
        errValid_s = 1'b0;
        errCode_s  = ST_OK;
        case (state_r)
            PS_HEADER: begin
                if (tValid && !magicOk_s) begin
                    errValid_s = 1'b1;
                    errCode_s  = ST_BAD_MAGIC;
                end else if (tValid && tLast) begin
                    errValid_s = 1'b1;
                    errCode_s  = ST_TRUNCATED;
                end else begin
                    errValid_s = 1'b0;
                end
            end
            PS_DATA: begin
                if (tValid) begin
                    ramWe_s = 1'b1;
                    if (!tLast) begin
                        errValid_s = 1'b1;
                        errCode_s  = ST_OVERLONG;
                    end else if (duplicate_s) begin
                        errValid_s = 1'b1;
                        errCode_s  = ST_DUPLICATE;
                    end else begin
                        errValid_s = 1'b0;
                    end
                end else begin
                    ramWe_s = 1'b0;
                end
            end
            PS_DISCARD: ramWe_s = 1'b0;
            default:    ramWe_s = 1'b0;
        endcase
    end

    // Capture the index field of a good header that opens a packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_r <= '0;
        end else if (state_r == PS_HEADER && tValid && magicOk_s && !tLast) begin
            index_r <= tData[INDEX_START_BIT +: INDEX_WIDTH];
        end else begin
            index_r <= index_r;
        end
    end

    // Bitmap next value: FA clear first, then this beat's write on top.
    always_comb begin
        bitmapNext_s = clearBitmap ? '0 : bitmap_r;
        if (ramWe_s) begin
            bitmapNext_s[index_r] = 1'b1;
        end else begin
            bitmapNext_s = bitmapNext_s;
        end
    end

    // Bitmap register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bitmap_r <= '0;
        end else begin
            bitmap_r <= bitmapNext_s;
        end
    end

    // Payload RAM; contents are not reset.
    always_ff @(posedge clk) begin
        if (!reset && ramWe_s) begin
            ram_r[index_r] <= tData;
        end
    end

    assign rdDataA  = ram_r[rdAddrA];
    assign rdDataB  = ram_r[rdAddrB];
    assign bitmap   = bitmap_r;
    assign errValid = errValid_s;
    assign errCode  = errCode_s;

endmodule

// File: rtl/fmps_read_links.sv
// fmps_read_links: receive-side FMPS monitor on the CCW and CW link taps.
// Tracks which FMPS indices arrived in the current FA cycle, reports
// completion / timeout through the CSR and serves the stored payload words.
// Optional feature macro: FMPS_TIMEOUT_EN (timeout counter and timeoutStrobe).
// Ports:
//   auClk, auReset             clock, synchronous active-high reset
//   csrStrobe, GPIO_OUT        CSR write: [IW:0] expected count, inhibit bits
//   csr                        {active, valid, 0.., expected count}
//   FAstrobe                   start of FA cycle
//   fmpsBitmapAll/Enabled      received indices (all / within expected count)
//   fmps*FASnapshot            previous cycle's bitmaps
//   fmpsEnabled                expected count non-zero
//   statusStrobe, statusCode   one-cycle error pulse with its code
//   timeoutStrobe              one-cycle timeout pulse
//   fmpsReadoutAddress/Readout random-access payload read, 1-cycle latency
//   uBreadoutStrobe/uBreadout  sequential payload reader
//   ccwInhibit, cwInhibit      CSR inhibit bits
//   ccwT*, cwT*                link taps
module fmps_read_links
    import fmps_pkg::*;
#(
    parameter int          INDEX_WIDTH     = 5,
    parameter logic [15:0] HEADER_MAGIC    = FMPS_HEADER_MAGIC,
    parameter int          INDEX_START_BIT = 10,
    parameter int          TIMEOUT_CYCLES  = 100000
) (
    input  logic                        auClk,
    input  logic                        auReset,
    input  logic                        csrStrobe,
    input  logic [31:0]                 GPIO_OUT,
    output logic [31:0]                 csr,
    input  logic                        FAstrobe,
    output logic [(2**INDEX_WIDTH)-1:0] fmpsBitmapAll,
    output logic [(2**INDEX_WIDTH)-1:0] fmpsBitmapEnabled,
    output logic                        fmpsEnabled,
    output logic [(2**INDEX_WIDTH)-1:0] fmpsBitmapAllFASnapshot,
    output logic [(2**INDEX_WIDTH)-1:0] fmpsEnableBitmapFASnapshot,
    output logic                        statusStrobe,
    output logic [2:0]                  statusCode,
    output logic                        timeoutStrobe,
    input  logic [INDEX_WIDTH-1:0]      fmpsReadoutAddress,
    output logic [31:0]                 fmpsReadout,
    input  logic                        uBreadoutStrobe,
    output logic [31:0]                 uBreadout,
    output logic                        ccwInhibit,
    output logic                        cwInhibit,
    input  logic                        ccwTVALID,
    input  logic                        ccwTLAST,
    input  logic [31:0]                 ccwTDATA,
    input  logic                        cwTVALID,
    input  logic                        cwTLAST,
    input  logic [31:0]                 cwTDATA
);

    localparam int DEPTH   = 2**INDEX_WIDTH;
    localparam int CNT_W   = INDEX_WIDTH + 1;
    localparam int CCW_INH = csrCcwInhibitBit(INDEX_WIDTH);
    localparam int CW_INH  = CCW_INH + 1;

    logic [CNT_W-1:0]       expectedCount_r;
    logic                   ccwInhibit_r;
    logic                   cwInhibit_r;
    logic                   active_r;
    logic                   valid_r;
    logic [DEPTH-1:0]       snapAll_r;
    logic [DEPTH-1:0]       snapEnabled_r;
    logic                   statusStrobe_r;
    logic [2:0]             statusCode_r;
    logic [31:0]            readout_r;
    logic [31:0]            ubReadout_r;
    logic [INDEX_WIDTH-1:0] ubPtr_r;

    logic [DEPTH-1:0]       ccwBitmap_s;
    logic [DEPTH-1:0]       cwBitmap_s;
    logic [DEPTH-1:0]       bitmapAll_s;
    logic [DEPTH-1:0]       enableMask_s;
    logic [DEPTH-1:0]       bitmapEnabled_s;
    logic [CNT_W-1:0]       enabledCount_s;
    logic                   complete_s;
    logic                   timeoutHit_s;
    logic [31:0]            ccwRdA_s, ccwRdB_s, cwRdA_s, cwRdB_s;
    logic                   ccwErr_s, cwErr_s;
    logic [2:0]             ccwCode_s, cwCode_s;
    logic [31:0]            readoutNext_s;
    logic [31:0]            ubReadoutNext_s;
    logic [31:0]            csr_s;
    logic                   unusedGpio_s;

    assign unusedGpio_s = ^{GPIO_OUT[31:CW_INH+1], GPIO_OUT[CCW_INH-1:CNT_W]};

    fmps_link_parser #(
        .INDEX_WIDTH    (INDEX_WIDTH),
        .HEADER_MAGIC   (HEADER_MAGIC),
        .INDEX_START_BIT(INDEX_START_BIT)
    ) uCcwParser (
        .clk        (auClk),
        .reset      (auReset),
        .clearBitmap(FAstrobe),
        .tValid     (ccwTVALID),
        .tLast      (ccwTLAST),
        .tData      (ccwTDATA),
        .rdAddrA    (fmpsReadoutAddress),
        .rdAddrB    (ubPtr_r),
        .rdDataA    (ccwRdA_s),
        .rdDataB    (ccwRdB_s),
        .bitmap     (ccwBitmap_s),
        .errValid   (ccwErr_s),
        .errCode    (ccwCode_s)
    );

    fmps_link_parser #(
        .INDEX_WIDTH    (INDEX_WIDTH),
        .HEADER_MAGIC   (HEADER_MAGIC),
        .INDEX_START_BIT(INDEX_START_BIT)
    ) uCwParser (
        .clk        (auClk),
        .reset      (auReset),
        .clearBitmap(FAstrobe),
        .tValid     (cwTVALID),
        .tLast      (cwTLAST),
        .tData      (cwTDATA),
        .rdAddrA    (fmpsReadoutAddress),
        .rdAddrB    (ubPtr_r),
        .rdDataA    (cwRdA_s),
        .rdDataB    (cwRdB_s),
        .bitmap     (cwBitmap_s),
        .errValid   (cwErr_s),
        .errCode    (cwCode_s)
    );

    assign bitmapAll_s     = ccwBitmap_s | cwBitmap_s;
    assign bitmapEnabled_s = bitmapAll_s & enableMask_s;

    // Enable mask and popcount of the enabled bitmap.
    always_comb begin
        enableMask_s   = '0;
        enabledCount_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            enableMask_s[i] = (CNT_W'(i) < expectedCount_r);
            enabledCount_s  = enabledCount_s + {{(CNT_W-1){1'b0}}, bitmapEnabled_s[i]};
        end
    end

    assign complete_s = (enabledCount_s == expectedCount_r) && (expectedCount_r != '0);

    // CSR write fields.
    always_ff @(posedge auClk) begin
        if (auReset) begin
            expectedCount_r <= '0;
            ccwInhibit_r    <= 1'b0;
            cwInhibit_r     <= 1'b0;
        end else if (csrStrobe) begin
            expectedCount_r <= GPIO_OUT[CNT_W-1:0];
            ccwInhibit_r    <= GPIO_OUT[CCW_INH];
            cwInhibit_r     <= GPIO_OUT[CW_INH];
        end else begin
            expectedCount_r <= expectedCount_r;
        end
    end

    // FA cycle state: FAstrobe restarts, completion wins over timeout.
    always_ff @(posedge auClk) begin
        if (auReset) begin
            active_r <= 1'b0;
            valid_r  <= 1'b0;
        end else if (FAstrobe) begin
            active_r <= 1'b1;
            valid_r  <= 1'b0;
        end else if (active_r && complete_s) begin
            active_r <= 1'b0;
            valid_r  <= 1'b1;
        end else if (timeoutHit_s) begin
            active_r <= 1'b0;
        end else begin
            active_r <= active_r;
        end
    end

    // Previous-cycle bitmaps latched at FAstrobe.
    always_ff @(posedge auClk) begin
        if (auReset) begin
            snapAll_r     <= '0;
            snapEnabled_r <= '0;
        end else if (FAstrobe) begin
            snapAll_r     <= bitmapAll_s;
            snapEnabled_r <= bitmapEnabled_s;
        end else begin
            snapAll_r     <= snapAll_r;
        end
    end

    // Error pulse; CCW has priority when both links report together.
    always_ff @(posedge auClk) begin
        if (auReset) begin
            statusStrobe_r <= 1'b0;
            statusCode_r   <= ST_OK;
        end else begin
            statusStrobe_r <= ccwErr_s | cwErr_s;
            if (ccwErr_s) begin
                statusCode_r <= ccwCode_s;
            end else if (cwErr_s) begin
                statusCode_r <= cwCode_s;
            end else begin
                statusCode_r <= statusCode_r;
            end
        end
    end

    // Read selection: CCW word if its bit is set, else CW word, else zero.
    always_comb begin
        readoutNext_s   = 32'd0;
        ubReadoutNext_s = 32'd0;
        if (ccwBitmap_s[fmpsReadoutAddress]) begin
            readoutNext_s = ccwRdA_s;
        end else if (cwBitmap_s[fmpsReadoutAddress]) begin
            readoutNext_s = cwRdA_s;
        end else begin
            readoutNext_s = 32'd0;
        end
        if (ccwBitmap_s[ubPtr_r]) begin
            ubReadoutNext_s = ccwRdB_s;
        end else if (cwBitmap_s[ubPtr_r]) begin
            ubReadoutNext_s = cwRdB_s;
        end else begin
            ubReadoutNext_s = 32'd0;
        end
    end

    // Registered readouts and the sequential reader pointer.
    always_ff @(posedge auClk) begin
        if (auReset) begin
            readout_r   <= 32'd0;
            ubReadout_r <= 32'd0;
            ubPtr_r     <= '0;
        end else begin
            readout_r   <= readoutNext_s;
            ubReadout_r <= ubReadoutNext_s;
            if (FAstrobe) begin
                ubPtr_r <= '0;
            end else if (uBreadoutStrobe) begin
                ubPtr_r <= ubPtr_r + {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                ubPtr_r <= ubPtr_r;
            end
        end
    end

`ifdef FMPS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] timeoutCount_r;
    logic            timeoutStrobe_r;

    assign timeoutHit_s = active_r && !FAstrobe && !complete_s &&
                          (timeoutCount_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Cycles since FAstrobe, held once the limit is reached.
    always_ff @(posedge auClk) begin
        if (auReset) begin
            timeoutCount_r <= '0;
        end else if (FAstrobe) begin
            timeoutCount_r <= '0;
        end else if (active_r && timeoutCount_r != TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeoutCount_r <= timeoutCount_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            timeoutCount_r <= timeoutCount_r;
        end
    end

    // One-cycle timeout pulse.
    always_ff @(posedge auClk) begin
        if (auReset) begin
            timeoutStrobe_r <= 1'b0;
        end else begin
            timeoutStrobe_r <= timeoutHit_s;
        end
    end

    assign timeoutStrobe = timeoutStrobe_r;
`else
    localparam int unusedTimeout = TIMEOUT_CYCLES;
    assign timeoutHit_s  = 1'b0;
    assign timeoutStrobe = 1'b0;
`endif

    // CSR readback assembly.
    always_comb begin
        csr_s                 = 32'd0;
        csr_s[CSR_ACTIVE_BIT] = active_r;
        csr_s[CSR_VALID_BIT]  = valid_r;
        csr_s[CNT_W-1:0]      = expectedCount_r;
    end

    assign csr                        = csr_s;
    assign fmpsBitmapAll              = bitmapAll_s;
    assign fmpsBitmapEnabled          = bitmapEnabled_s;
    assign fmpsEnabled                = (expectedCount_r != '0);
    assign fmpsBitmapAllFASnapshot    = snapAll_r;
    assign fmpsEnableBitmapFASnapshot = snapEnabled_r;
    assign statusStrobe               = statusStrobe_r;
    assign statusCode                 = statusCode_r;
    assign fmpsReadout                = readout_r;
    assign uBreadout                  = ubReadout_r;
    assign ccwInhibit                 = ccwInhibit_r;
    assign cwInhibit                  = cwInhibit_r;

endmodule

// File: tb/tb_fmps_read_links.sv
module tb_fmps_read_links;

    localparam int IW = 5;
    localparam int TO = 300;

    logic        auClk = 1'b0;
    logic        auReset = 1'b1;
    logic        csrStrobe = 1'b0;
    logic [31:0] GPIO_OUT = 32'd0;
    logic [31:0] csr;
    logic        FAstrobe = 1'b0;
    logic [31:0] fmpsBitmapAll, fmpsBitmapEnabled;
    logic        fmpsEnabled;
    logic [31:0] fmpsBitmapAllFASnapshot, fmpsEnableBitmapFASnapshot;
    logic        statusStrobe;
    logic [2:0]  statusCode;
    logic        timeoutStrobe;
    logic [4:0]  fmpsReadoutAddress = 5'd0;
    logic [31:0] fmpsReadout;
    logic        uBreadoutStrobe = 1'b0;
    logic [31:0] uBreadout;
    logic        ccwInhibit, cwInhibit;
    logic        ccwTVALID = 1'b0, ccwTLAST = 1'b0, cwTVALID = 1'b0, cwTLAST = 1'b0;
    logic [31:0] ccwTDATA = 32'd0, cwTDATA = 32'd0;

    int          nVec = 0;
    int          nErr = 0;
    int          cyc = 0;
    logic [7:0]  cnt = 8'd0;
    logic [31:0] expWord [32];

    fmps_read_links #(
        .INDEX_WIDTH    (IW),
        .HEADER_MAGIC   (16'hB6CF),
        .INDEX_START_BIT(10),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .auClk                     (auClk),
        .auReset                   (auReset),
        .csrStrobe                 (csrStrobe),
        .GPIO_OUT                  (GPIO_OUT),
        .csr                       (csr),
        .FAstrobe                  (FAstrobe),
        .fmpsBitmapAll             (fmpsBitmapAll),
        .fmpsBitmapEnabled         (fmpsBitmapEnabled),
        .fmpsEnabled               (fmpsEnabled),
        .fmpsBitmapAllFASnapshot   (fmpsBitmapAllFASnapshot),
        .fmpsEnableBitmapFASnapshot(fmpsEnableBitmapFASnapshot),
        .statusStrobe              (statusStrobe),
        .statusCode                (statusCode),
        .timeoutStrobe             (timeoutStrobe),
        .fmpsReadoutAddress        (fmpsReadoutAddress),
        .fmpsReadout               (fmpsReadout),
        .uBreadoutStrobe           (uBreadoutStrobe),
        .uBreadout                 (uBreadout),
        .ccwInhibit                (ccwInhibit),
        .cwInhibit                 (cwInhibit),
        .ccwTVALID                 (ccwTVALID),
        .ccwTLAST                  (ccwTLAST),
        .ccwTDATA                  (ccwTDATA),
        .cwTVALID                  (cwTVALID),
        .cwTLAST                   (cwTLAST),
        .cwTDATA                   (cwTDATA)
    );

    always #5 auClk = ~auClk;
    always @(posedge auClk) cyc <= cyc + 1;

    function automatic logic [31:0] hdr(input logic [4:0] idx);
        return {16'hB6CF, 1'b0, idx, 10'd0};
    endfunction

    function automatic logic [31:0] dword(input logic [4:0] idx, input logic [7:0] c);
        return {3'b000, idx, 16'hCACA, c};
    endfunction

    // Inputs change at negedge; outputs are observed at the following negedge.
    task automatic pair(input bit vA, input logic [31:0] dA, input bit lA,
                        input bit vB, input logic [31:0] dB, input bit lB);
        @(negedge auClk);
        ccwTVALID = vA; ccwTDATA = dA; ccwTLAST = lA;
        cwTVALID  = vB; cwTDATA  = dB; cwTLAST  = lB;
        @(negedge auClk);
        ccwTVALID = 1'b0; ccwTLAST = 1'b0; cwTVALID = 1'b0; cwTLAST = 1'b0;
    endtask

    task automatic beat(input bit cw, input logic [31:0] d, input bit last);
        if (cw) pair(1'b0, 32'd0, 1'b0, 1'b1, d, last);
        else    pair(1'b1, d, last, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic sendPkt(input bit cw, input logic [4:0] idx, input logic [31:0] w);
        beat(cw, hdr(idx), 1'b0);
        beat(cw, w, 1'b1);
    endtask

    task automatic csrWrite(input logic [31:0] v);
        @(negedge auClk); csrStrobe = 1'b1; GPIO_OUT = v;
        @(negedge auClk); csrStrobe = 1'b0;
    endtask

    task automatic faPulse();
        @(negedge auClk); FAstrobe = 1'b1;
        @(negedge auClk); FAstrobe = 1'b0;
    endtask

    task automatic readAt(input logic [4:0] a);
        @(negedge auClk); fmpsReadoutAddress = a;
        @(negedge auClk);
    endtask

    task automatic test_reset();
        auReset = 1'b1;
        repeat (3) @(negedge auClk);
        nVec++; if (csr !== 32'd0) begin nErr++; $display("FAIL reset_csr: got %h expected %h", csr, 32'd0); end
        nVec++; if (fmpsBitmapAll !== 32'd0) begin nErr++; $display("FAIL reset_bitmap: got %h expected %h", fmpsBitmapAll, 32'd0); end
        nVec++; if ({statusStrobe, statusCode, timeoutStrobe} !== 5'd0) begin nErr++; $display("FAIL reset_status: got %b expected 00000", {statusStrobe, statusCode, timeoutStrobe}); end
        nVec++; if ({ccwInhibit, cwInhibit, fmpsEnabled} !== 3'd0) begin nErr++; $display("FAIL reset_flags: got %b expected 000", {ccwInhibit, cwInhibit, fmpsEnabled}); end
        nVec++; if ({fmpsReadout, uBreadout} !== 64'd0) begin nErr++; $display("FAIL reset_readout: got %h expected 0", {fmpsReadout, uBreadout}); end
        auReset = 1'b0;
        @(negedge auClk);
    endtask

    task automatic test_csr();
        csrWrite(32'h000C_0010);
        nVec++; if (csr !== 32'h0000_0010) begin nErr++; $display("FAIL csr_count: got %h expected %h", csr, 32'h10); end
        nVec++; if ({ccwInhibit, cwInhibit, fmpsEnabled} !== 3'b111) begin nErr++; $display("FAIL csr_inhibits: got %b expected 111", {ccwInhibit, cwInhibit, fmpsEnabled}); end
        csrWrite(32'h0000_0010);
        nVec++; if ({ccwInhibit, cwInhibit} !== 2'b00) begin nErr++; $display("FAIL csr_inhibit_clear: got %b expected 00", {ccwInhibit, cwInhibit}); end
    endtask

    task automatic test_full_cycle();
        logic [31:0] wA, wB;
        faPulse();
        nVec++; if (csr !== 32'h8000_0010) begin nErr++; $display("FAIL fa_active: got %h expected %h", csr, 32'h80000010); end
        for (int p = 0; p < 8; p++) begin
            wA = dword(5'(p), cnt);     cnt = cnt + 8'd1;
            wB = dword(5'(p + 8), cnt); cnt = cnt + 8'd1;
            expWord[p] = wA; expWord[p + 8] = wB;
            pair(1'b1, hdr(5'(p)), 1'b0, 1'b1, hdr(5'(p + 8)), 1'b0);
            pair(1'b1, wA, 1'b1, 1'b1, wB, 1'b1);
        end
        nVec++; if (fmpsBitmapAll !== 32'h0000_FFFF) begin nErr++; $display("FAIL full_bitmap: got %h expected %h", fmpsBitmapAll, 32'hFFFF); end
        nVec++; if (fmpsBitmapEnabled !== 32'h0000_FFFF) begin nErr++; $display("FAIL full_enabled: got %h expected %h", fmpsBitmapEnabled, 32'hFFFF); end
        nVec++; if (statusStrobe !== 1'b0) begin nErr++; $display("FAIL full_nostatus: got %b expected 0", statusStrobe); end
        nVec++; if (csr !== 32'h8000_0010) begin nErr++; $display("FAIL valid_latency: got %h expected %h", csr, 32'h80000010); end
        @(negedge auClk);
        nVec++; if (csr !== 32'h4000_0010) begin nErr++; $display("FAIL valid_set: got %h expected %h", csr, 32'h40000010); end
        for (int i = 0; i < 16; i++) begin
            readAt(5'(i));
            nVec++; if (fmpsReadout !== expWord[i]) begin nErr++; $display("FAIL readout_%0d: got %h expected %h", i, fmpsReadout, expWord[i]); end
        end
        readAt(5'd20);
        nVec++; if (fmpsReadout !== 32'd0) begin nErr++; $display("FAIL readout_unset: got %h expected 0", fmpsReadout); end
        nVec++; if (uBreadout !== expWord[0]) begin nErr++; $display("FAIL ub_first: got %h expected %h", uBreadout, expWord[0]); end
        for (int s = 0; s < 3; s++) begin
            @(negedge auClk); uBreadoutStrobe = 1'b1;
            @(negedge auClk); uBreadoutStrobe = 1'b0;
        end
        @(negedge auClk);
        nVec++; if (uBreadout !== expWord[3]) begin nErr++; $display("FAIL ub_third: got %h expected %h", uBreadout, expWord[3]); end
        for (int s = 0; s < 29; s++) begin
            @(negedge auClk); uBreadoutStrobe = 1'b1;
            @(negedge auClk); uBreadoutStrobe = 1'b0;
        end
        @(negedge auClk);
        nVec++; if (uBreadout !== expWord[0]) begin nErr++; $display("FAIL ub_wrap: got %h expected %h", uBreadout, expWord[0]); end
    endtask

    task automatic test_snapshot();
        csrWrite(32'h0000_0008);
        faPulse();
        nVec++; if (fmpsBitmapAllFASnapshot !== 32'h0000_FFFF) begin nErr++; $display("FAIL snap_all: got %h expected %h", fmpsBitmapAllFASnapshot, 32'hFFFF); end
        nVec++; if (fmpsEnableBitmapFASnapshot !== 32'h0000_00FF) begin nErr++; $display("FAIL snap_en: got %h expected %h", fmpsEnableBitmapFASnapshot, 32'hFF); end
        nVec++; if (fmpsBitmapAll !== 32'd0) begin nErr++; $display("FAIL snap_cleared: got %h expected 0", fmpsBitmapAll); end
        nVec++; if (csr !== 32'h8000_0008) begin nErr++; $display("FAIL snap_csr: got %h expected %h", csr, 32'h80000008); end
    endtask

    task automatic test_errors();
        logic [31:0] w;
        beat(1'b0, {16'hB6CE, 1'b0, 5'd3, 10'd0}, 1'b0);
        nVec++; if ({statusStrobe, statusCode} !== 4'b1_001) begin nErr++; $display("FAIL bad_magic: got %b expected 1001", {statusStrobe, statusCode}); end
        beat(1'b0, 32'hDEAD_BEEF, 1'b1);
        nVec++; if ({statusStrobe, fmpsBitmapAll} !== 33'd0) begin nErr++; $display("FAIL bad_magic_discard: got %h expected 0", {statusStrobe, fmpsBitmapAll}); end
        w = dword(5'd3, 8'hA3);
        sendPkt(1'b0, 5'd3, w);
        nVec++; if (fmpsBitmapAll !== 32'h0000_0008) begin nErr++; $display("FAIL after_discard: got %h expected %h", fmpsBitmapAll, 32'h8); end
        sendPkt(1'b1, 5'd5, dword(5'd5, 8'h01));
        nVec++; if (statusStrobe !== 1'b0) begin nErr++; $display("FAIL dup_first: got %b expected 0", statusStrobe); end
        w = dword(5'd5, 8'h02);
        sendPkt(1'b1, 5'd5, w);
        nVec++; if ({statusStrobe, statusCode} !== 4'b1_010) begin nErr++; $display("FAIL duplicate: got %b expected 1010", {statusStrobe, statusCode}); end
        readAt(5'd5);
        nVec++; if (fmpsReadout !== w) begin nErr++; $display("FAIL dup_overwrite: got %h expected %h", fmpsReadout, w); end
        beat(1'b0, hdr(5'd7), 1'b1);
        nVec++; if ({statusStrobe, statusCode} !== 4'b1_011) begin nErr++; $display("FAIL truncated: got %b expected 1011", {statusStrobe, statusCode}); end
        nVec++; if (fmpsBitmapAll !== 32'h0000_0028) begin nErr++; $display("FAIL trunc_bitmap: got %h expected %h", fmpsBitmapAll, 32'h28); end
        beat(1'b0, hdr(5'd9), 1'b0);
        beat(1'b0, dword(5'd9, 8'h09), 1'b0);
        nVec++; if ({statusStrobe, statusCode} !== 4'b1_100) begin nErr++; $display("FAIL overlong: got %b expected 1100", {statusStrobe, statusCode}); end
        nVec++; if (fmpsBitmapAll !== 32'h0000_0228) begin nErr++; $display("FAIL overlong_bitmap: got %h expected %h", fmpsBitmapAll, 32'h228); end
        beat(1'b0, 32'h1234_5678, 1'b1);
        sendPkt(1'b0, 5'd10, dword(5'd10, 8'h0A));
        nVec++; if ({statusStrobe, fmpsBitmapAll} !== {1'b0, 32'h0000_0628}) begin nErr++; $display("FAIL overlong_recover: got %h expected %h", {statusStrobe, fmpsBitmapAll}, {1'b0, 32'h628}); end
        pair(1'b1, {16'hB6CE, 16'h0000}, 1'b1, 1'b1, hdr(5'd11), 1'b1);
        nVec++; if ({statusStrobe, statusCode} !== 4'b1_001) begin nErr++; $display("FAIL both_err_ccw: got %b expected 1001", {statusStrobe, statusCode}); end
        @(negedge auClk);
        nVec++; if (statusStrobe !== 1'b0) begin nErr++; $display("FAIL both_err_single: got %b expected 0", statusStrobe); end
        w = dword(5'd5, 8'hC5);
        sendPkt(1'b0, 5'd5, w);
        readAt(5'd5);
        nVec++; if (fmpsReadout !== w) begin nErr++; $display("FAIL ccw_priority: got %h expected %h", fmpsReadout, w); end
    endtask

    task automatic test_timeout();
        int c0;
        int tHit;
        bit seen;
        csrWrite(32'h0000_0010);
        faPulse();
        c0 = cyc;
        for (int p = 0; p < 15; p++) sendPkt(1'b0, 5'(p), dword(5'(p), 8'(p)));
        nVec++; if (csr !== 32'h8000_0010) begin nErr++; $display("FAIL partial_active: got %h expected %h", csr, 32'h80000010); end
        seen = 1'b0;
        tHit = 0;
`ifdef FMPS_TIMEOUT_EN
        for (int k = 0; k < TO + 50 && !seen; k++) begin
            @(negedge auClk);
            if (timeoutStrobe === 1'b1) begin seen = 1'b1; tHit = cyc - c0; end
        end
        nVec++; if (seen !== 1'b1) begin nErr++; $display("FAIL timeout_seen: got %b expected 1", seen); end
        nVec++; if (tHit !== TO) begin nErr++; $display("FAIL timeout_cycles: got %0d expected %0d", tHit, TO); end
        nVec++; if (csr[31:30] !== 2'b00) begin nErr++; $display("FAIL timeout_csr: got %b expected 00", csr[31:30]); end
        @(negedge auClk);
        nVec++; if (timeoutStrobe !== 1'b0) begin nErr++; $display("FAIL timeout_pulse: got %b expected 0", timeoutStrobe); end
`else
        for (int k = 0; k < TO + 20; k++) begin
            @(negedge auClk);
            if (timeoutStrobe !== 1'b0) seen = 1'b1;
        end
        nVec++; if (seen !== 1'b0) begin nErr++; $display("FAIL timeout_disabled: got %b expected 0", seen); end
        nVec++; if (csr[31:30] !== 2'b10) begin nErr++; $display("FAIL still_active: got %b expected 10", csr[31:30]); end
`endif
    endtask

    task automatic test_reset_mid_packet();
        logic [31:0] w;
        csrWrite(32'h0004_0010);
        nVec++; if ({ccwInhibit, cwInhibit} !== 2'b10) begin nErr++; $display("FAIL ccw_inhibit: got %b expected 10", {ccwInhibit, cwInhibit}); end
        faPulse();
        beat(1'b0, hdr(5'd2), 1'b0);
        @(negedge auClk); auReset = 1'b1;
        repeat (2) @(negedge auClk);
        nVec++; if ({csr, fmpsBitmapAll, fmpsBitmapAllFASnapshot, fmpsEnableBitmapFASnapshot} !== 128'd0) begin nErr++; $display("FAIL midreset_regs: got %h expected 0", {csr, fmpsBitmapAll, fmpsBitmapAllFASnapshot, fmpsEnableBitmapFASnapshot}); end
        nVec++; if ({ccwInhibit, cwInhibit, fmpsEnabled, statusStrobe, statusCode, timeoutStrobe} !== 8'd0) begin nErr++; $display("FAIL midreset_flags: got %b expected 0", {ccwInhibit, cwInhibit, fmpsEnabled, statusStrobe, statusCode, timeoutStrobe}); end
        nVec++; if ({fmpsReadout, uBreadout} !== 64'd0) begin nErr++; $display("FAIL midreset_readout: got %h expected 0", {fmpsReadout, uBreadout}); end
        @(negedge auClk); auReset = 1'b0;
        w = dword(5'd6, 8'h66);
        sendPkt(1'b0, 5'd6, w);
        nVec++; if ({statusStrobe, fmpsBitmapAll} !== {1'b0, 32'h0000_0040}) begin nErr++; $display("FAIL post_reset_pkt: got %h expected %h", {statusStrobe, fmpsBitmapAll}, {1'b0, 32'h40}); end
        readAt(5'd6);
        nVec++; if (fmpsReadout !== w) begin nErr++; $display("FAIL post_reset_readout: got %h expected %h", fmpsReadout, w); end
    endtask

    initial begin
        test_reset();
        test_csr();
        test_full_cycle();
        test_snapshot();
        test_errors();
        test_timeout();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
